vib_driver: RTL and testbench

Vibration-motor driver for the robot's haptic/alarm path, and the actuator counterpart to the shake-sensor input. It accepts a 2-bit vibration level with a start pulse. It then drives a PWM-gated motor enable through a burst pattern: a single burst, a triple burst, or continuous vibration until stopped. It reports `busy`, and pulses `done` when the pattern completes or is aborted.

---
 rtl/vib_driver.sv | 135 +++++++++++++
 tb/tb_vib_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vib_driver.sv
// Vibration-motor driver: PWM-gated single, triple or continuous bursts with stop/abort.
// Optional VIB_RETRIGGER_EN lets a new start restart a running pattern.
module vib_driver #(
  parameter int PWM_PERIOD = 2500,
  parameter int DUTY       = 1875,
  parameter int ON_CYC     = 12_500_000,
  parameter int OFF_CYC    = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] level,
  input  logic       stop,
  output logic       motor_pwm,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PWM_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);
  localparam logic [PH_W-1:0]  ON_LAST  = PH_W'(ON_CYC - 1);
  localparam logic [PH_W-1:0]  OFF_LAST = PH_W'(OFF_CYC - 1);

`ifdef VIB_RETRIGGER_EN
  localparam bit RETRIG_EN = 1'b1;
`else
  localparam bit RETRIG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_FIN} state_t;

  state_t            state;
  logic [1:0]        lvl_q;
  logic [1:0]        burst_cnt;
  logic [PH_W-1:0]   phase_cnt;
  logic [PWM_W-1:0]  pwm_cnt;

  logic              running_c;
  logic              launch_c;
  logic              on_end_c;
  logic              off_end_c;
  logic [PWM_W-1:0]  pwm_nxt_c;

  // Signed compare keeps DUTY = 0 (never high) and DUTY = PWM_PERIOD (always high) exact.
  function automatic logic duty_hi(input int c);
    return c < DUTY;
  endfunction

  assign running_c = (state == S_ON) || (state == S_OFF);
  assign launch_c  = start && ((state == S_IDLE) || (RETRIG_EN && running_c));
  assign on_end_c  = (phase_cnt == ON_LAST);
  assign off_end_c = (phase_cnt == OFF_LAST);
  assign pwm_nxt_c = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_W'(1);

  // Outputs are registered from the state being entered, so they track state with no lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lvl_q     <= '0;
      burst_cnt <= '0;
      phase_cnt <= '0;
      pwm_cnt   <= '0;
      motor_pwm <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (running_c && stop) begin
        state     <= S_FIN;
        done      <= 1'b1;
        busy      <= 1'b0;
        motor_pwm <= 1'b0;
      end else if (launch_c) begin
        phase_cnt <= '0;
        pwm_cnt   <= '0;
        burst_cnt <= '0;
        if (level == 2'd0) begin
          state     <= S_FIN;
          done      <= 1'b1;
          busy      <= 1'b0;
          motor_pwm <= 1'b0;
        end else begin
          state     <= S_ON;
          lvl_q     <= level;
          busy      <= 1'b1;
          motor_pwm <= duty_hi(0);
        end
      end else begin
        case (state)
          S_ON: begin
            if (on_end_c) begin
              phase_cnt <= '0;
              pwm_cnt   <= '0;
              if (lvl_q == 2'd3) begin
                motor_pwm <= duty_hi(0);
              end else if ((lvl_q == 2'd2) && (burst_cnt != 2'd2)) begin
                state     <= S_OFF;
                burst_cnt <= burst_cnt + 2'd1;
                motor_pwm <= 1'b0;
              end else begin
                state     <= S_FIN;
                burst_cnt <= burst_cnt + 2'd1;
                done      <= 1'b1;
                busy      <= 1'b0;
                motor_pwm <= 1'b0;
              end
            end else begin
              phase_cnt <= phase_cnt + PH_W'(1);
              pwm_cnt   <= pwm_nxt_c;
              motor_pwm <= duty_hi(int'(pwm_nxt_c));
            end
          end
          S_OFF: begin
            if (off_end_c) begin
              state     <= S_ON;
              phase_cnt <= '0;
              pwm_cnt   <= '0;
              motor_pwm <= duty_hi(0);
            end else begin
              phase_cnt <= phase_cnt + PH_W'(1);
            end
          end
          S_FIN: begin
            state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vib_driver.sv
// Directed self-checking bench for vib_driver (PWM_PERIOD=4, DUTY=3, ON_CYC=8, OFF_CYC=4),
// plus a DUTY=0 instance. Expectations follow VIB_RETRIGGER_EN when it is defined.
module tb_vib_driver;

  logic       clk;
  logic       rst;
  logic       start;
  logic       start0;
  logic [1:0] level;
  logic       stop;
  logic       motor_pwm, busy, done;
  logic       motor0, busy0, done0;

  int checks;
  int failures;

  logic [63:0] cm, cb, cd, cm0, cb0, cd0;

  vib_driver #(.PWM_PERIOD(4), .DUTY(3), .ON_CYC(8), .OFF_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .level(level), .stop(stop),
    .motor_pwm(motor_pwm), .busy(busy), .done(done)
  );

  vib_driver #(.PWM_PERIOD(4), .DUTY(0), .ON_CYC(8), .OFF_CYC(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .level(level), .stop(stop),
    .motor_pwm(motor0), .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample n cycles into bit vectors; optionally raise stop/start before the edge after sample k.
  task automatic capture(input int n, input int stop_at, input int start_at, input logic [1:0] lvl);
    cm = '0; cb = '0; cd = '0; cm0 = '0; cb0 = '0; cd0 = '0;
    for (int i = 0; i < n; i++) begin
      cm[i] = motor_pwm; cb[i] = busy; cd[i] = done;
      cm0[i] = motor0; cb0[i] = busy0; cd0[i] = done0;
      if (i == stop_at) stop = 1'b1;
      if (i == start_at) begin
        start = 1'b1;
        level = lvl;
      end
      step();
      stop  = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic kick(input logic [1:0] lvl);
    level = lvl;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; stop = 1'b0; level = 2'd0;
    step(); step();
    chk_eq("reset_outs", 64'({motor_pwm, busy, done}), 64'h0);
    rst = 1'b0;
    step();

    // stop while idle does nothing
    stop = 1'b1; step(); stop = 1'b0;
    chk_eq("idle_stop", 64'({motor_pwm, busy, done}), 64'h0);

    // level 1 single burst
    kick(2'd1);
    capture(8, -1, -1, 2'd0);
    chk_eq("l1_motor", cm, 64'h77);
    chk_eq("l1_busy", cb, 64'hFF);
    chk_eq("l1_done_early", cd, 64'h0);
    chk_eq("l1_fin", 64'({motor_pwm, busy, done}), 64'h1);
    // start during FIN is ignored
    level = 2'd1; start = 1'b1; step(); start = 1'b0;
    chk_eq("fin_start_ignored", 64'({motor_pwm, busy, done}), 64'h0);
    step();

    // level 2 triple burst
    kick(2'd2);
    capture(33, -1, -1, 2'd0);
    chk_eq("l2_motor", cm, 64'h0_7707_7077);
    chk_eq("l2_busy", cb, 64'h0_FFFF_FFFF);
    chk_eq("l2_done", cd, 64'h1_0000_0000);
    chk_eq("l2_overlap", cb & cd, 64'h0);
    chk_eq("l2_after", 64'({motor_pwm, busy, done}), 64'h0);

    // level 3 continuous, stop sampled 20 edges after start
    kick(2'd3);
    capture(20, 19, -1, 2'd0);
    chk_eq("l3_motor", cm, 64'h7_7777);
    chk_eq("l3_busy", cb, 64'hF_FFFF);
    chk_eq("l3_stop", 64'({motor_pwm, busy, done}), 64'h1);
    step();
    chk_eq("l3_after", 64'({motor_pwm, busy, done}), 64'h0);

    // level 0 completes immediately
    kick(2'd0);
    chk_eq("l0_done", 64'({motor_pwm, busy, done}), 64'h1);
    step();
    chk_eq("l0_after", 64'({motor_pwm, busy, done}), 64'h0);

    // DUTY = 0 keeps the motor off for the whole burst
    level = 2'd1; start0 = 1'b1; step(); start0 = 1'b0;
    capture(9, -1, -1, 2'd0);
    chk_eq("d0_motor", cm0, 64'h0);
    chk_eq("d0_busy", cb0, 64'hFF);
    chk_eq("d0_done", cd0, 64'h100);

    // reset during the second OFF gap of level 2
    kick(2'd2);
    capture(21, -1, -1, 2'd0);
    chk_eq("rst_pre_busy", 64'(busy), 64'h1);
    rst = 1'b1; step(); rst = 1'b0;
    chk_eq("rst_mid", 64'({motor_pwm, busy, done}), 64'h0);
    capture(4, -1, -1, 2'd0);
    chk_eq("rst_no_done", cd, 64'h0);
    chk_eq("rst_no_busy", cb | cm, 64'h0);

    // start with level 1 during ON cycle 5
    kick(2'd1);
    capture(15, -1, 4, 2'd1);
`ifdef VIB_RETRIGGER_EN
    chk_eq("retrig_motor", cm, 64'hEF7);
    chk_eq("retrig_busy", cb, 64'h1FFF);
    chk_eq("retrig_done", cd, 64'h2000);
`else
    chk_eq("retrig_motor", cm, 64'h77);
    chk_eq("retrig_busy", cb, 64'hFF);
    chk_eq("retrig_done", cd, 64'h100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
